// File: rtl/psram_access_arbiter_pkg.sv
// Shared encodings for the PSRAM command-port arbiter: FSM states,
// owner codes and controller command codes.
package psram_access_arbiter_pkg;

  // Arbiter FSM state (kept as plain constants for legacy tools).
  typedef logic [1:0] t_arb_state;

  localparam t_arb_state ST_IDLE     = 2'd0;
  localparam t_arb_state ST_GRANT_WR = 2'd1;
  localparam t_arb_state ST_GRANT_RD = 2'd2;
  localparam t_arb_state ST_RELEASE  = 2'd3;

  // Value driven on the owner port.
  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_WR   = 2'd1;
  localparam logic [1:0] OWNER_RD   = 2'd2;

  // Controller command direction.
  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Direction of the command a granted owner issues.
  function automatic logic cmd_for_state(input t_arb_state st);
    logic cmd;
    case (st)
      ST_GRANT_WR: cmd = CMD_WRITE;
      ST_GRANT_RD: cmd = CMD_READ;
      default:     cmd = CMD_READ;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/psram_access_arbiter_grant_watchdog.sv
// Grant watchdog: counts cycles while a grant is held and raises a
// sticky error once the count reaches GRANT_TIMEOUT. The grant itself
// is never revoked; the counter simply saturates.
module psram_access_arbiter_grant_watchdog #(
  parameter int GRANT_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic timeout_err
);

  localparam int CNT_W = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(GRANT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);

  logic [CNT_W-1:0] count_r;

  // Per-grant cycle counter with saturation and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r     <= {CNT_W{1'b0}};
      timeout_err <= 1'b0;
    end else if (!active) begin
      count_r <= {CNT_W{1'b0}};
    end else if (count_r != CNT_MAX) begin
      count_r <= count_r + CNT_W'(1);
      if (count_r == CNT_LAST) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/psram_access_arbiter.sv
// Two-requester arbiter for the PSRAM controller command port.
// The writer has priority, but after MAX_WR_STREAK consecutive writer
// grants with the reader waiting, the reader is served next. Each grant
// carries exactly one command; a guard phase after every grant keeps a
// new owner off the bus until the controller's burst has finished.
module psram_access_arbiter
  import psram_access_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 21,
  parameter int MAX_WR_STREAK  = 4,
  parameter int GRANT_TIMEOUT  = 1024,
  parameter int RELEASE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_rq,
  input  logic                  wr_cmd_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_ack,
  input  logic                  rd_rq,
  input  logic                  rd_cmd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic                  rd_data_valid,
  input  logic                  ctrl_busy,
  input  logic                  ctrl_data_valid,
  output logic                  ctrl_cmd,
  output logic                  ctrl_cmd_en,
  output logic [ADDR_WIDTH-1:0] ctrl_addr,
  output logic [1:0]            owner,
  output logic                  timeout_err,
  output logic                  protocol_err
);

  localparam int STREAK_W = $clog2(MAX_WR_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);

  // Guard counter counts completed release cycles; RELEASE_CYCLES >= 1.
  localparam int GUARD_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(RELEASE_CYCLES - 1);

  t_arb_state            state_r;
  logic [STREAK_W-1:0]   streak_r;
  logic [GUARD_W-1:0]    guard_r;
  logic                  cmd_taken_r;

  logic                  starve_s;
  logic                  owner_rq_s;
  logic                  owner_cmd_en_s;
  logic                  foreign_cmd_en_s;
  logic [ADDR_WIDTH-1:0] owner_addr_s;
  logic                  grant_active_s;
  logic                  guard_done_s;

  // Select the current owner's handshake and flag commands from anyone else.
  always_comb begin
    owner_rq_s       = 1'b0;
    owner_cmd_en_s   = 1'b0;
    foreign_cmd_en_s = 1'b0;
    owner_addr_s     = {ADDR_WIDTH{1'b0}};
    case (state_r)
      ST_GRANT_WR: begin
        owner_rq_s       = wr_rq;
        owner_cmd_en_s   = wr_cmd_en;
        owner_addr_s     = wr_addr;
        foreign_cmd_en_s = rd_cmd_en;
      end
      ST_GRANT_RD: begin
        owner_rq_s       = rd_rq;
        owner_cmd_en_s   = rd_cmd_en;
        owner_addr_s     = rd_addr;
        foreign_cmd_en_s = wr_cmd_en;
      end
      default: begin
        foreign_cmd_en_s = wr_cmd_en | rd_cmd_en;
      end
    endcase
  end

  // Decode starvation, grant activity and guard completion.
  always_comb begin
    starve_s       = 1'b0;
    grant_active_s = 1'b0;
    guard_done_s   = 1'b0;
    if (streak_r == STREAK_MAX) begin
      starve_s = 1'b1;
    end else begin
      starve_s = 1'b0;
    end
    if ((state_r == ST_GRANT_WR) || (state_r == ST_GRANT_RD)) begin
      grant_active_s = 1'b1;
    end else begin
      grant_active_s = 1'b0;
    end
    if (guard_r == GUARD_LAST) begin
      guard_done_s = 1'b1;
    end else begin
      guard_done_s = 1'b0;
    end
  end

  // Arbitration FSM with registered ack/owner/command outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      streak_r     <= {STREAK_W{1'b0}};
      guard_r      <= {GUARD_W{1'b0}};
      cmd_taken_r  <= 1'b0;
      wr_ack       <= 1'b0;
      rd_ack       <= 1'b0;
      owner        <= OWNER_NONE;
      ctrl_cmd_en  <= 1'b0;
      ctrl_cmd     <= CMD_READ;
      ctrl_addr    <= {ADDR_WIDTH{1'b0}};
      protocol_err <= 1'b0;
    end else begin
      ctrl_cmd_en <= 1'b0;
      if (foreign_cmd_en_s) begin
        protocol_err <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          cmd_taken_r <= 1'b0;
          guard_r     <= {GUARD_W{1'b0}};
          if (wr_rq && !(rd_rq && starve_s)) begin
            state_r <= ST_GRANT_WR;
            wr_ack  <= 1'b1;
            owner   <= OWNER_WR;
            // Only writer grants that make the reader wait extend the streak.
            if (rd_rq) begin
              streak_r <= streak_r + STREAK_W'(1);
            end else begin
              streak_r <= {STREAK_W{1'b0}};
            end
          end else if (rd_rq) begin
            state_r  <= ST_GRANT_RD;
            rd_ack   <= 1'b1;
            owner    <= OWNER_RD;
            streak_r <= {STREAK_W{1'b0}};
          end else begin
            streak_r <= {STREAK_W{1'b0}};
          end
        end
        ST_GRANT_WR, ST_GRANT_RD: begin
          if (owner_cmd_en_s) begin
            if (cmd_taken_r) begin
              protocol_err <= 1'b1;
            end else begin
              ctrl_cmd_en <= 1'b1;
              ctrl_addr   <= owner_addr_s;
              ctrl_cmd    <= cmd_for_state(state_r);
              cmd_taken_r <= 1'b1;
            end
          end
          // A command issued together with the rq drop is still forwarded above.
          if (!owner_rq_s) begin
            state_r <= ST_RELEASE;
            wr_ack  <= 1'b0;
            rd_ack  <= 1'b0;
            owner   <= OWNER_NONE;
            guard_r <= {GUARD_W{1'b0}};
          end
        end
        ST_RELEASE: begin
          if (!guard_done_s) begin
            guard_r <= guard_r + GUARD_W'(1);
          end
          if (guard_done_s && !ctrl_busy) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          wr_ack  <= 1'b0;
          rd_ack  <= 1'b0;
          owner   <= OWNER_NONE;
        end
      endcase
    end
  end

  // Read data only reaches the reader while it owns the bus.
  assign rd_data_valid = ctrl_data_valid & (owner == OWNER_RD);

  psram_access_arbiter_grant_watchdog #(
    .GRANT_TIMEOUT(GRANT_TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .active     (grant_active_s),
    .timeout_err(timeout_err)
  );

endmodule

// File: tb/tb_psram_access_arbiter.sv
// Directed, table-driven bench for psram_access_arbiter with hand-written
// sequences for the grant timeout and reset behaviour.
module tb_psram_access_arbiter;

  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_rq = 1'b0, wr_cmd_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          rd_rq = 1'b0, rd_cmd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          ctrl_busy = 1'b0, ctrl_data_valid = 1'b0;
  logic          wr_ack, rd_ack, rd_data_valid, ctrl_cmd, ctrl_cmd_en;
  logic [AW-1:0] ctrl_addr;
  logic [1:0]    owner;
  logic          timeout_err, protocol_err;

  psram_access_arbiter #(
    .ADDR_WIDTH(AW), .MAX_WR_STREAK(4), .GRANT_TIMEOUT(16), .RELEASE_CYCLES(1)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_rq(wr_rq), .wr_cmd_en(wr_cmd_en), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .rd_rq(rd_rq), .rd_cmd_en(rd_cmd_en), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data_valid(rd_data_valid), .ctrl_busy(ctrl_busy),
    .ctrl_data_valid(ctrl_data_valid), .ctrl_cmd(ctrl_cmd),
    .ctrl_cmd_en(ctrl_cmd_en), .ctrl_addr(ctrl_addr), .owner(owner),
    .timeout_err(timeout_err), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rst;
    logic          wr_rq;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_rq;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          busy;
    logic          dv;
  } in_t;

  typedef struct packed {
    logic          wack;
    logic          rack;
    logic [1:0]    own;
    logic          en;
    logic          cmd;
    logic [AW-1:0] addr;
    logic          dv;
    logic          perr;
    logic          terr;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t want;
  } vec_t;

  vec_t  vecs[$];
  string names[$];
  int    total = 0;
  int    passed = 0;

  function automatic in_t mk_in(int rst, int wrq, int wen, int wad,
                                int rrq, int ren, int rad, int busy, int dv);
    in_t r;
    r.rst = 1'(rst);   r.wr_rq = 1'(wrq); r.wr_en = 1'(wen); r.wr_addr = AW'(wad);
    r.rd_rq = 1'(rrq); r.rd_en = 1'(ren); r.rd_addr = AW'(rad);
    r.busy = 1'(busy); r.dv = 1'(dv);
    return r;
  endfunction

  function automatic out_t mk_ex(int wa, int ra, int own, int en, int cmd,
                                 int addr, int dv, int perr, int terr);
    out_t r;
    r.wack = 1'(wa); r.rack = 1'(ra); r.own = 2'(own); r.en = 1'(en);
    r.cmd = 1'(cmd); r.addr = AW'(addr); r.dv = 1'(dv);
    r.perr = 1'(perr); r.terr = 1'(terr);
    return r;
  endfunction

  task automatic add(input string nm, input in_t s, input out_t w);
    vec_t v;
    v.stim = s;
    v.want = w;
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  function automatic out_t sample();
    out_t r;
    r.wack = wr_ack; r.rack = rd_ack; r.own = owner; r.en = ctrl_cmd_en;
    r.cmd = ctrl_cmd; r.addr = ctrl_addr; r.dv = rd_data_valid;
    r.perr = protocol_err; r.terr = timeout_err;
    return r;
  endfunction

  task automatic drive(input in_t s);
    reset = s.rst; wr_rq = s.wr_rq; wr_cmd_en = s.wr_en; wr_addr = s.wr_addr;
    rd_rq = s.rd_rq; rd_cmd_en = s.rd_en; rd_addr = s.rd_addr;
    ctrl_busy = s.busy; ctrl_data_valid = s.dv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string nm, input out_t got, input out_t want);
    total++;
    if (got === want) begin
      passed++;
    end else begin
      $display("FAIL %s: got wa=%b ra=%b own=%0d en=%b cmd=%b addr=%h dv=%b perr=%b terr=%b, expected wa=%b ra=%b own=%0d en=%b cmd=%b addr=%h dv=%b perr=%b terr=%b",
               nm, got.wack, got.rack, got.own, got.en, got.cmd, got.addr, got.dv, got.perr, got.terr,
               want.wack, want.rack, want.own, want.en, want.cmd, want.addr, want.dv, want.perr, want.terr);
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic want);
    total++;
    if (got === want) begin
      passed++;
    end else begin
      $display("FAIL %s: got %b, expected %b", nm, got, want);
    end
  endtask

  localparam int A4 = 'h00400, AWR = 'h1ABCDE, A10 = 'h00010, AB = 'h0ABCD, A123 = 'h00123;

  initial begin
    // ---------------- vector table ----------------
    add("reset",          mk_in(1,0,0,0,       0,0,0,0,0), mk_ex(0,0,0,0,0,0,0,0,0));
    add("idle",           mk_in(0,0,0,0,       0,0,0,0,0), mk_ex(0,0,0,0,0,0,0,0,0));
    add("rd_grant",       mk_in(0,0,0,0,       1,0,0,0,0), mk_ex(0,1,2,0,0,0,0,0,0));
    add("rd_cmd",         mk_in(0,0,0,0,       1,1,A4,0,0), mk_ex(0,1,2,1,0,A4,0,0,0));
    add("rd_dv_routed",   mk_in(0,0,0,0,       1,0,0,1,1), mk_ex(0,1,2,0,0,A4,1,0,0));
    add("rd_drop",        mk_in(0,0,0,0,       0,0,0,1,0), mk_ex(0,0,0,0,0,A4,0,0,0));
    add("rel_busy_dv",    mk_in(0,1,0,0,       0,0,0,1,1), mk_ex(0,0,0,0,0,A4,0,0,0));
    add("rel_busy2",      mk_in(0,1,0,0,       0,0,0,1,0), mk_ex(0,0,0,0,0,A4,0,0,0));
    add("rel_busy3",      mk_in(0,1,0,0,       0,0,0,1,0), mk_ex(0,0,0,0,0,A4,0,0,0));
    add("rel_free",       mk_in(0,1,0,0,       0,0,0,0,0), mk_ex(0,0,0,0,0,A4,0,0,0));
    add("wr_grant",       mk_in(0,1,0,0,       0,0,0,0,0), mk_ex(1,0,1,0,0,A4,0,0,0));
    add("wr_cmd",         mk_in(0,1,1,AWR,     0,0,0,0,1), mk_ex(1,0,1,1,1,AWR,0,0,0));
    add("wr_dv_dropped",  mk_in(0,1,0,0,       0,0,0,0,1), mk_ex(1,0,1,0,1,AWR,0,0,0));
    add("wr_drop",        mk_in(0,0,0,0,       0,0,0,0,0), mk_ex(0,0,0,0,1,AWR,0,0,0));
    add("wr_rel",         mk_in(0,0,0,0,       0,0,0,0,0), mk_ex(0,0,0,0,1,AWR,0,0,0));
    add("both_wr1",       mk_in(0,1,0,0,       1,0,0,0,0), mk_ex(1,0,1,0,1,AWR,0,0,0));
    add("wr1_cmd",        mk_in(0,1,1,A10,     1,0,0,0,0), mk_ex(1,0,1,1,1,A10,0,0,0));
    add("wr1_drop",       mk_in(0,0,0,0,       1,0,0,0,0), mk_ex(0,0,0,0,1,A10,0,0,0));
    add("wr1_rel",        mk_in(0,1,0,0,       1,0,0,0,0), mk_ex(0,0,0,0,1,A10,0,0,0));
    for (int g = 2; g <= 4; g++) begin
      add($sformatf("both_wr%0d", g),  mk_in(0,1,0,0,1,0,0,0,0), mk_ex(1,0,1,0,1,A10,0,0,0));
      add($sformatf("wr%0d_drop", g),  mk_in(0,0,0,0,1,0,0,0,0), mk_ex(0,0,0,0,1,A10,0,0,0));
      add($sformatf("wr%0d_rel", g),   mk_in(0,1,0,0,1,0,0,0,0), mk_ex(0,0,0,0,1,A10,0,0,0));
    end
    add("starve_rd",      mk_in(0,1,0,0,       1,0,0,0,0), mk_ex(0,1,2,0,1,A10,0,0,0));
    add("rd_cmd2",        mk_in(0,1,0,0,       1,1,AB,0,0), mk_ex(0,1,2,1,0,AB,0,0,0));
    add("rd_second_cmd",  mk_in(0,1,0,0,       1,1,'h1FFFFF,0,0), mk_ex(0,1,2,0,0,AB,0,1,0));
    add("perr_sticky",    mk_in(0,1,0,0,       1,0,0,0,0), mk_ex(0,1,2,0,0,AB,0,1,0));
    add("rd2_drop",       mk_in(0,1,0,0,       0,0,0,0,0), mk_ex(0,0,0,0,0,AB,0,1,0));
    add("rd2_rel",        mk_in(0,1,0,0,       0,0,0,0,0), mk_ex(0,0,0,0,0,AB,0,1,0));
    add("wr_after_rd",    mk_in(0,1,0,0,       1,0,0,0,0), mk_ex(1,0,1,0,0,AB,0,1,0));
    add("reset_mid_grant",mk_in(1,1,1,'h777,   1,0,0,0,0), mk_ex(0,0,0,0,0,0,0,0,0));
    add("post_reset_idle",mk_in(0,0,0,0,       0,0,0,0,0), mk_ex(0,0,0,0,0,0,0,0,0));
    add("regrant_rd",     mk_in(0,0,0,0,       1,0,0,0,0), mk_ex(0,1,2,0,0,0,0,0,0));
    add("foreign_wr_cmd", mk_in(0,0,1,'h155555,1,0,0,0,0), mk_ex(0,1,2,0,0,0,0,1,0));
    add("drop_with_cmd",  mk_in(0,0,0,0,       0,1,A123,0,0), mk_ex(0,0,0,1,0,A123,0,1,0));
    add("rel_idle",       mk_in(0,0,0,0,       0,0,0,0,0), mk_ex(0,0,0,0,0,A123,0,1,0));
    add("reset2",         mk_in(1,0,0,0,       0,0,0,0,0), mk_ex(0,0,0,0,0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stim);
      step();
      check_out(names[i], sample(), vecs[i].want);
    end

    // ---------------- grant timeout (GRANT_TIMEOUT = 16) ----------------
    drive(mk_in(0,0,0,0,1,0,0,0,0));
    step();
    check_bit("to_grant_ack", rd_ack, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step();
      check_bit($sformatf("to_cycle%0d", k), timeout_err, (k >= 16) ? 1'b1 : 1'b0);
    end
    check_bit("to_grant_kept", rd_ack, 1'b1);
    rd_rq = 1'b0;
    step();
    check_out("to_release", sample(), mk_ex(0,0,0,0,0,0,0,0,1));
    step();
    wr_rq = 1'b1;
    step();
    check_out("to_sticky_wr", sample(), mk_ex(1,0,1,0,0,0,0,0,1));
    reset = 1'b1;
    step();
    check_out("to_reset_clear", sample(), mk_ex(0,0,0,0,0,0,0,0,0));
    reset = 1'b0;
    wr_rq = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/psram_access_arbiter.md
Name: psram_access_arbiter

Overview:
Two-requester arbiter for the single PSRAM controller command port. The camera frame writer and the frame downloader (reader) each run an rq/ack handshake and issue burst commands. The arbiter grants one owner at a time and muxes that owner's command and address to the controller. It routes read-data-valid back to the reader, and applies writer priority bounded by an anti-starvation limit.

Parameters:
ADDR_WIDTH, 21, PSRAM word address width
MAX_WR_STREAK, 4, consecutive writer grants allowed while reader is waiting
GRANT_TIMEOUT, 1024, max cycles a grant may be held before timeout_err
RELEASE_CYCLES, 1, guard idle cycles between grants

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_rq  in  1  writer requests bus; held until its burst is finished
wr_cmd_en  in  1  writer burst command strobe, one cycle
wr_addr  in  ADDR_WIDTH  writer burst address, valid with wr_cmd_en
wr_ack  out  1  writer owns bus (level)
rd_rq  in  1  reader requests bus; held until its burst is finished
rd_cmd_en  in  1  reader burst command strobe, one cycle
rd_addr  in  ADDR_WIDTH  reader burst address, valid with rd_cmd_en
rd_ack  out  1  reader owns bus (level)
rd_data_valid  out  1  controller read-data-valid gated to reader
ctrl_busy  in  1  controller executing a burst
ctrl_data_valid  in  1  controller read data valid
ctrl_cmd  out  1  0 = read, 1 = write
ctrl_cmd_en  out  1  command strobe to controller
ctrl_addr  out  ADDR_WIDTH  command address
owner  out  2  0 none, 1 writer, 2 reader
timeout_err  out  1  sticky: grant exceeded GRANT_TIMEOUT
protocol_err  out  1  sticky: cmd_en from non-owner, or second cmd_en within one grant

Behaviour:
- Reset values:
  - All outputs are 0.
  - state = IDLE.
  - streak counter, timeout counter and guard counter are 0.
  - Reset mid-grant drops ack and owner on the next edge. No ctrl_cmd_en is issued.
- IDLE:
  - wr_rq only -> GRANT_WR.
  - rd_rq only -> GRANT_RD.
  - Both asserted -> GRANT_RD if streak == MAX_WR_STREAK, otherwise GRANT_WR.
  - Neither asserted -> stay in IDLE.
  - Granting transition registers ack and owner, so ack rises 1 cycle after rq is seen in IDLE.
- GRANT_WR / GRANT_RD:
  - ack is held.
  - The owner's cmd_en is registered into ctrl_cmd_en, ctrl_addr and ctrl_cmd, with 1-cycle latency. ctrl_cmd_en is a 1-cycle pulse.
  - Exactly one command is accepted per grant. A later cmd_en sets protocol_err and is not forwarded.
  - A non-owner cmd_en is ignored and sets protocol_err.
  - Owner rq deasserted -> RELEASE; ack drops on that edge.
  - Timeout counter increments each cycle in a grant. On reaching GRANT_TIMEOUT it sets timeout_err; the grant is kept and the counter saturates.
- Streak counter:
  - Increments on each writer grant made while rd_rq is high, saturating at MAX_WR_STREAK.
  - Clears on every reader grant.
  - Clears in IDLE when rd_rq is low.
- RELEASE:
  - owner = 0.
  - Waits for ctrl_busy low AND RELEASE_CYCLES elapsed, then -> IDLE.
  - A re-grant therefore never overlaps a running burst.
- rd_data_valid = ctrl_data_valid & (owner == reader), combinational, zero latency.
- ctrl_data_valid while owner != reader is dropped, with no error.
- Simultaneous rq drop and cmd_en from the owner: the command is forwarded, then RELEASE.
- Widths:
  - Streak counter: $clog2(MAX_WR_STREAK+1) bits.
  - Timeout counter: $clog2(GRANT_TIMEOUT+1) bits.
  - Addresses pass unmodified.

Decomposition:
- Package PsramArbiterTypes holds:
  - t_arb_state enum {IDLE, GRANT_WR, GRANT_RD, RELEASE}.
  - Owner encodings OWNER_NONE/WR/RD.
  - CMD_READ / CMD_WRITE constants.
- The shared PSRAM_Utilities package supplies any burst-length helpers.
- One natural sub-module: arb_grant_watchdog, the timeout counter plus sticky timeout_err, cleared by reset.

Test Plan:
- Single reader request: rd_rq=1, then rd_cmd_en with rd_addr=0x00400 -> rd_ack high after 1 cycle; ctrl_cmd_en pulse 1 cycle after cmd_en with ctrl_addr=0x00400, ctrl_cmd=0; owner=2.
- Reader data routing: rd_rq drop -> ack low same edge, owner=0. With ctrl_busy=1 for 5 cycles, the next grant is deferred until busy clears + 1. ctrl_data_valid pulses during the reader grant appear on rd_data_valid; pulses during a writer grant do not.
- Simultaneous request, priority: wr_rq and rd_rq rise in the same cycle -> wr_ack first, ctrl_cmd=1.
- Simultaneous request, starvation: with MAX_WR_STREAK=4 and both requesters held continuously -> grant sequence WR,WR,WR,WR,RD,WR...
- Protocol errors: writer cmd_en while reader owns -> no ctrl_cmd_en, protocol_err=1 sticky. A second rd_cmd_en in the same grant -> protocol_err.
- Timeout: GRANT_TIMEOUT=16, reader holds rq for 20 cycles -> timeout_err rises on cycle 16 of the grant and stays 1 until reset.
- Reset mid-grant: reset during GRANT_WR -> next edge all outputs 0, state IDLE, errors cleared. Re-request is granted normally.
